main_mem_responder: RTL and testbench
=====================================

# main_mem_responder

Main-memory side of the instruction-cache line-fill protocol. Responds to a line read request (`re_mm` plus line address) by streaming one cache line as `WORDS_PER_LINE` data beats, each qualified by a one-cycle `mem_valid_mm` pulse. It contains the backing word array and a preload write port used by boot logic and benches. It sits between the cache controller's line buffer and the rest of the memory system, and it models configurable access latency and inter-beat wait states.

## Interface
- `DATA_W`, default 32: word width.
- `ADDR_W`, default 12: word-address width. The array holds 2^ADDR_W words.
- `WORDS_PER_LINE`, default 4: beats per line. Must be a power of 2 and at least 2.
- `LATENCY`, default 3: edges from request acceptance to the first beat. Must be at least 1.
- `BEAT_GAP`, default 0: idle cycles inserted between consecutive beats.

Ports (clock and reset first):
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `re_mm`, in, 1: line read request. Level signal, held high by the initiator for the whole fetch.
- `addr_mm`, in, ADDR_W: word address of the requested line. The low log2(WORDS_PER_LINE) bits are ignored.
- `mem_valid_mm`, out, 1: `data_mm` carries a valid beat this cycle.
- `data_mm`, out, DATA_W: beat data.
- `last_mm`, out, 1: high together with `mem_valid_mm` on the final beat of a line.
- `busy`, out, 1: a request is accepted and not yet completed or aborted.
- `init_we`, in, 1: preload write enable.
- `init_addr`, in, ADDR_W: preload word address.
- `init_wdata`, in, DATA_W: preload data.

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: latency countdown.
  - BURST: issuing beats, with gap countdown between them.
  - REARM: waiting for `re_mm` to go low.
- IDLE: if `re_mm` is high at an edge, latch line base = `addr_mm` with its offset bits zeroed, clear the beat counter, and go to WAIT. `busy` goes high.
- WAIT: counts LATENCY-1 further edges, then goes to BURST. When LATENCY=1, the first beat issues in the cycle immediately after acceptance.
- BURST: beat k (k = 0..WORDS_PER_LINE-1) presents `mem[line_base | k]`, in ascending offset order with no wrap. Between beats, `mem_valid_mm` stays low for BEAT_GAP cycles. `last_mm` is high only on beat WORDS_PER_LINE-1.
- After the last beat, go to REARM. If `re_mm` is already low, REARM exits to IDLE in one cycle; otherwise it stays in REARM until `re_mm` is low. This prevents a held request from re-triggering.
- Abort: if `re_mm` is sampled low in WAIT or BURST, go to IDLE. No further beats are issued; the next cycle has `mem_valid_mm`=0 and `busy`=0.
- `addr_mm` is sampled only at acceptance. Later changes are ignored until the next request.
- Preload: `init_we` writes `init_wdata` to `init_addr` at the edge. It is allowed in any state. A beat reading the same word in the same cycle returns the old contents (read-before-write). Later beats see the new value.
- Array contents are not cleared by `reset`.

## Timing
- `mem_valid_mm`, `data_mm`, `last_mm`, and `busy` are registered outputs.
- Reset values: `mem_valid_mm`=0, `last_mm`=0, `busy`=0, `data_mm`=0, state=IDLE.
- `data_mm` holds its last beat value while `mem_valid_mm`=0.
- If the request is sampled at edge E0, beat k is valid in the cycle after edge E0 + LATENCY - 1 + k·(BEAT_GAP+1). With defaults, beats are valid in cycles 3, 4, 5, and 6 after acceptance.
- Total occupancy from acceptance to IDLE: LATENCY + (WORDS_PER_LINE-1)·(BEAT_GAP+1) + 1 cycles when `re_mm` drops right after the last beat.
- Compatibility with the initiator: it writes its line buffer on every `mem_valid_mm` and leaves its fetch state on `full & mem_valid_mm`, dropping `re_mm` the next cycle. The block therefore supports a new request no earlier than 2 cycles after the last beat.
- Reset asserted mid-burst takes priority over every other condition. The next cycle is IDLE with all outputs at their reset values, and partial beats are not resumed.

## Test plan
- **Single line, defaults.** Preload words 0x10..0x13 with 0xA0..0xA3; hold `re_mm`=1 with `addr_mm`=0x12. Required: `mem_valid_mm` high in cycles 3..6 after acceptance with data 0xA0, 0xA1, 0xA2, 0xA3; `last_mm` high only on 0xA3; `busy` low once `re_mm` drops.
- **Held request.** Keep `re_mm` high for 5 cycles after the last beat. Required: no second burst. Drop `re_mm` for 1 cycle and re-raise it. Required: a new burst with first beat 3 cycles after the re-raise.
- **Abort.** Drop `re_mm` after beat 1 is delivered. Required: no beat 2 or 3, `busy`=0 the next cycle, and a subsequent request returns the full line correctly.
- **Reset mid-burst.** Assert `reset` during beat 2. Required: all outputs 0 next cycle and the preloaded array intact, verified by re-reading 0xA0..0xA3.
- **Wait states.** With LATENCY=1 and BEAT_GAP=2, request line 0x10. Required: beats in cycles 1, 4, 7, and 10 after acceptance, with `mem_valid_mm` low in between.
- **Preload collision.** Write 0x55 to word 0x11 in the same cycle beat 1 reads it. Required: beat 1 returns 0xA1, and the next line read returns 0x55.

Source files
------------

// File: rtl/main_mem_responder.sv
// main_mem_responder: main-memory side of the instruction-cache line fill.
// A line request streams WORDS_PER_LINE beats from the backing array after a
// configurable latency, with optional idle cycles between beats.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   re_mm, addr_mm    line read request (level) and word address of the line
//   mem_valid_mm      registered beat strobe
//   data_mm           registered beat data (holds while mem_valid_mm is low)
//   last_mm           registered, high on the final beat of a line
//   busy              registered, high from acceptance until return to idle
//   init_we/addr/wdata  preload write port into the backing array
module main_mem_responder #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned LATENCY        = 3,
  parameter int unsigned BEAT_GAP       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re_mm,
  input  logic [ADDR_W-1:0] addr_mm,
  output logic              mem_valid_mm,
  output logic [DATA_W-1:0] data_mm,
  output logic              last_mm,
  output logic              busy,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wdata
);

  localparam int unsigned OFF_W     = $clog2(WORDS_PER_LINE);
  localparam int unsigned DEPTH     = 1 << ADDR_W;
  // Wait counter holds at most LATENCY-2; gap counter holds at most BEAT_GAP.
  localparam int unsigned WAIT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned WAIT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;
  localparam int unsigned GAP_W     = (BEAT_GAP > 0) ? $clog2(BEAT_GAP + 1) : 1;

  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(WORDS_PER_LINE - 1);
  localparam logic [OFF_W-1:0]  LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_REARM = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   line_q, line_d;
  logic [OFF_W-1:0]    beat_q, beat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [GAP_W-1:0]    gap_q, gap_d;

  logic                issue_c;
  logic                last_c;
  logic [ADDR_W-1:0]   rd_addr_c;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Backing array preload; never cleared by reset.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_wdata;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      line_q       <= '0;
      beat_q       <= '0;
      wait_q       <= '0;
      gap_q        <= '0;
      mem_valid_mm <= 1'b0;
      last_mm      <= 1'b0;
      busy         <= 1'b0;
      data_mm      <= '0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      beat_q       <= beat_d;
      wait_q       <= wait_d;
      gap_q        <= gap_d;
      mem_valid_mm <= issue_c;
      last_mm      <= last_c;
      busy         <= (state_d != ST_IDLE);
      // Same-edge preload write is not visible here: read returns old word.
      if (issue_c) begin
        data_mm <= mem[rd_addr_c];
      end
    end
  end

  // Next-state logic; a low re_mm in WAIT/BURST aborts the fetch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (re_mm) begin
          state_d = (LATENCY == 1) ? ST_BURST : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!re_mm) begin
          state_d = ST_IDLE;
        end else if (wait_q == '0) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!re_mm) begin
          state_d = ST_IDLE;
        end else if ((gap_q == '0) && (beat_q == LAST_BEAT)) begin
          state_d = ST_REARM;
        end
      end
      ST_REARM: begin
        if (!re_mm) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat issue and counter updates. Beat 0 issues on the edge that ends the
  // latency countdown; with LATENCY=1 that is the acceptance edge itself.
  always_comb begin
    line_d    = line_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    gap_d     = gap_q;
    issue_c   = 1'b0;
    last_c    = 1'b0;
    rd_addr_c = line_q | ADDR_W'(beat_q);
    unique case (state_q)
      ST_IDLE: begin
        if (re_mm) begin
          line_d = addr_mm & ~OFF_MASK;
          beat_d = '0;
          wait_d = WAIT_W'(WAIT_INIT);
          if (LATENCY == 1) begin
            issue_c   = 1'b1;
            rd_addr_c = addr_mm & ~OFF_MASK;
            beat_d    = OFF_W'(1);
            gap_d     = GAP_W'(BEAT_GAP);
          end
        end
      end
      ST_WAIT: begin
        if (re_mm) begin
          if (wait_q == '0) begin
            issue_c = 1'b1;
            beat_d  = OFF_W'(1);
            gap_d   = GAP_W'(BEAT_GAP);
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
      end
      ST_BURST: begin
        if (re_mm) begin
          if (gap_q == '0) begin
            issue_c = 1'b1;
            last_c  = (beat_q == LAST_BEAT);
            beat_d  = beat_q + OFF_W'(1);
            gap_d   = GAP_W'(BEAT_GAP);
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
      end
      ST_REARM: begin
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: a default-parameter instance and a
// LATENCY=1/BEAT_GAP=2 instance share clock, reset and the preload port.
module tb_main_mem_responder;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 12;

  logic              clk;
  logic              reset;
  logic              re_mm, re2;
  logic [ADDR_W-1:0] addr_mm, addr2;
  logic              mem_valid_mm, valid2;
  logic [DATA_W-1:0] data_mm, data2;
  logic              last_mm, last2;
  logic              busy, busy2;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_wdata;

  int checks;
  int errors;

  main_mem_responder dut (
    .clk(clk), .reset(reset), .re_mm(re_mm), .addr_mm(addr_mm),
    .mem_valid_mm(mem_valid_mm), .data_mm(data_mm), .last_mm(last_mm),
    .busy(busy), .init_we(init_we), .init_addr(init_addr),
    .init_wdata(init_wdata)
  );

  main_mem_responder #(.LATENCY(1), .BEAT_GAP(2)) dut_ws (
    .clk(clk), .reset(reset), .re_mm(re2), .addr_mm(addr2),
    .mem_valid_mm(valid2), .data_mm(data2), .last_mm(last2),
    .busy(busy2), .init_we(init_we), .init_addr(init_addr),
    .init_wdata(init_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Six cycles of a default-timing fetch (re_mm already high); optionally
  // writes 0x55 to word 0x11 on the edge following cycle 'inject'.
  task automatic expect_line(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3, input int inject);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c >= 3) begin
        chk({tag, "_valid"}, 64'(mem_valid_mm), 64'd1);
        chk({tag, "_data"}, 64'(data_mm), 64'(e[c-3]));
        chk({tag, "_last"}, 64'(last_mm), (c == 6) ? 64'd1 : 64'd0);
      end else begin
        chk({tag, "_valid"}, 64'(mem_valid_mm), 64'd0);
        chk({tag, "_last"}, 64'(last_mm), 64'd0);
      end
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      if (c == inject) begin
        init_we    = 1'b1;
        init_addr  = 12'h011;
        init_wdata = 32'h55;
      end else begin
        init_we = 1'b0;
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    re_mm      = 1'b0;
    re2        = 1'b0;
    addr_mm    = '0;
    addr2      = '0;
    init_we    = 1'b0;
    init_addr  = '0;
    init_wdata = '0;

    tick();
    tick();
    chk("rst_valid", 64'(mem_valid_mm), 64'd0);
    chk("rst_last", 64'(last_mm), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(data_mm), 64'd0);
    chk("rst_ws_valid", 64'(valid2), 64'd0);
    chk("rst_ws_busy", 64'(busy2), 64'd0);
    reset = 1'b0;

    // Preload words 0x10..0x13.
    for (int i = 0; i < 4; i++) begin
      init_we    = 1'b1;
      init_addr  = 12'h010 + 12'(i);
      init_wdata = 32'hA0 + 32'(i);
      tick();
    end
    init_we = 1'b0;

    // Single line from an unaligned address; then held request.
    addr_mm = 12'h012;
    re_mm   = 1'b1;
    expect_line("line", 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_valid", 64'(mem_valid_mm), 64'd0);
    end
    re_mm = 1'b0;
    tick();
    chk("held_drop_busy", 64'(busy), 64'd0);
    chk("held_drop_valid", 64'(mem_valid_mm), 64'd0);
    chk("held_data_hold", 64'(data_mm), 64'hA3);
    re_mm = 1'b1;
    expect_line("rearm", 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0);
    re_mm = 1'b0;
    tick();
    chk("rearm_drop_busy", 64'(busy), 64'd0);

    // Abort after beat 1.
    addr_mm = 12'h010;
    re_mm   = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("abort_pre_valid", 64'(mem_valid_mm), (c >= 3) ? 64'd1 : 64'd0);
    end
    chk("abort_beat1", 64'(data_mm), 64'hA1);
    re_mm = 1'b0;
    tick();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(mem_valid_mm), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_beat", 64'(mem_valid_mm), 64'd0);
    end
    chk("abort_data_hold", 64'(data_mm), 64'hA1);
    addr_mm = 12'h013;
    re_mm   = 1'b1;
    expect_line("post_abort", 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0);
    re_mm = 1'b0;
    tick();

    // Reset during beat 2.
    addr_mm = 12'h010;
    re_mm   = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
    end
    chk("pre_rst_beat2", 64'(data_mm), 64'hA2);
    reset = 1'b1;
    tick();
    chk("midrst_valid", 64'(mem_valid_mm), 64'd0);
    chk("midrst_last", 64'(last_mm), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_data", 64'(data_mm), 64'd0);
    reset = 1'b0;
    re_mm = 1'b0;
    tick();
    chk("post_rst_idle", 64'(mem_valid_mm), 64'd0);
    re_mm = 1'b1;
    expect_line("post_rst", 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0);
    re_mm = 1'b0;
    tick();

    // Wait states: LATENCY=1, BEAT_GAP=2 -> beats in cycles 1, 4, 7, 10.
    addr2 = 12'h010;
    re2   = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if ((c % 3) == 1) begin
        chk("ws_valid", 64'(valid2), 64'd1);
        chk("ws_data", 64'(data2), 64'(32'hA0 + 32'((c - 1) / 3)));
        chk("ws_last", 64'(last2), (c == 10) ? 64'd1 : 64'd0);
      end else begin
        chk("ws_gap_valid", 64'(valid2), 64'd0);
      end
      chk("ws_busy", 64'(busy2), 64'd1);
    end
    re2 = 1'b0;
    tick();
    chk("ws_drop_busy", 64'(busy2), 64'd0);

    // Preload collision on the edge that reads beat 1.
    addr_mm = 12'h010;
    re_mm   = 1'b1;
    expect_line("collide", 32'hA0, 32'hA1, 32'hA2, 32'hA3, 3);
    re_mm = 1'b0;
    tick();
    re_mm = 1'b1;
    expect_line("after_collide", 32'hA0, 32'h55, 32'hA2, 32'hA3, 0);
    re_mm = 1'b0;
    tick();
    chk("final_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
